// File: rtl/alu_share_if.sv
// alu_share_if: request, ALU and response signals of the shared-ALU arbiter
interface alu_share_if #(
  parameter int DATA_WIDTH = 32,
  parameter int FUNC_WIDTH = 4
);
  logic                  req0_valid, req0_ready, req1_valid, req1_ready;
  logic [DATA_WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic [FUNC_WIDTH-1:0] req0_func, req1_func;
  logic [DATA_WIDTH-1:0] alu_a, alu_b, alu_result;
  logic [FUNC_WIDTH-1:0] alu_func;
  logic                  alu_zero;
  logic                  rsp_valid, rsp_ready, rsp_id, rsp_zero, rsp_err;
  logic [DATA_WIDTH-1:0] rsp_result;
  logic [15:0]           op_count;
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_func, req1_valid, req1_a, req1_b, req1_func,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_func,
    input  alu_result, alu_zero,
    output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, op_count,
    input  rsp_ready
  );
  modport master (
    output req0_valid, req0_a, req0_b, req0_func, req1_valid, req1_a, req1_b, req1_func,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_func,
    output alu_result, alu_zero,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_err, op_count,
    output rsp_ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter: round-robin sharing of one combinational ALU between two requesters
module alu_share_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int FUNC_WIDTH = 4
) (
  input logic        clk,
  input logic        rst,
  alu_share_if.slave bus
);
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t                state;
  logic                  last_grant, gnt, slot_open, accept, op_id;
  logic [DATA_WIDTH-1:0] op_a, op_b, rsp_result;
  logic [FUNC_WIDTH-1:0] op_func;
  logic                  rsp_valid, rsp_id, rsp_zero, rsp_err;
  logic [15:0]           op_count;
  always_comb begin
    slot_open = !rst && (state == IDLE || (state == HOLD && bus.rsp_ready));
    gnt       = (bus.req0_valid && bus.req1_valid) ? !last_grant : bus.req1_valid;
    accept    = slot_open && (bus.req0_valid || bus.req1_valid);
  end
  assign bus.req0_ready = accept && !gnt;
  assign bus.req1_ready = accept && gnt;
  assign bus.alu_a      = op_a;
  assign bus.alu_b      = op_b;
  assign bus.alu_func   = op_func;
  assign bus.rsp_valid  = rsp_valid;
  assign bus.rsp_id     = rsp_id;
  assign bus.rsp_result = rsp_result;
  assign bus.rsp_zero   = rsp_zero;
  assign bus.rsp_err    = rsp_err;
  assign bus.op_count   = op_count;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      op_id      <= 1'b0;
      op_a       <= '0;
      op_b       <= '0;
      op_func    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_result <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
      op_count   <= '0;
    end else begin
      if (accept) begin
        op_a       <= gnt ? bus.req1_a : bus.req0_a;
        op_b       <= gnt ? bus.req1_b : bus.req0_b;
        op_func    <= gnt ? bus.req1_func : bus.req0_func;
        op_id      <= gnt;
        last_grant <= gnt;
      end
      if (state == EXEC) begin
        rsp_valid  <= 1'b1;
        rsp_id     <= op_id;
        rsp_result <= bus.alu_result;
        rsp_zero   <= bus.alu_zero;
        rsp_err    <= op_func > FUNC_WIDTH'(9);
      end
      if (state == HOLD && bus.rsp_ready) begin
        rsp_valid <= 1'b0;
        op_count  <= op_count + 16'd1;
      end
      state <= accept ? EXEC : state == EXEC ? HOLD : (state == HOLD && !bus.rsp_ready) ? HOLD : IDLE;
    end
  end
endmodule

// File: doc/alu_share_arbiter.md
ALU_SHARE_ARBITER -- requirements
Module: alu_share_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width.
REQ-002 SHALL have parameter FUNC_WIDTH, default 4, ALU function code width.
REQ-003 SHALL have one clock and a synchronous, active-high reset.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset; sampled on clk.
REQ-006 reqN_valid  input  1  requester N (N=0,1) presents an operation.
REQ-007 reqN_ready  output  1  requester N operation accepted this cycle.
REQ-008 reqN_a, reqN_b  input  DATA_WIDTH  requester N operands.
REQ-009 reqN_func  input  FUNC_WIDTH  requester N ALU function code.
REQ-010 alu_a, alu_b  output  DATA_WIDTH  operands driven to the shared ALU.
REQ-011 alu_func  output  FUNC_WIDTH  function code driven to the shared ALU.
REQ-012 alu_result  input  DATA_WIDTH  combinational ALU result.
REQ-013 alu_zero  input  1  ALU zero flag.
REQ-014 rsp_valid  output  1  response available.
REQ-015 rsp_ready  input  1  consumer accepts response.
REQ-016 rsp_id  output  1  requester index owning the response.
REQ-017 rsp_result  output  DATA_WIDTH  captured ALU result.
REQ-018 rsp_zero  output  1  captured zero flag.
REQ-019 rsp_err  output  1  function code outside legal set 0..9.
REQ-020 op_count  output  16  number of completed responses, wraps 16'hFFFF -> 0.

Function
REQ-021 FSM states SHALL be IDLE, EXEC and HOLD, each held in a registered state variable.
REQ-022 The accept slot SHALL be open in IDLE, or in HOLD while rsp_ready=1.
REQ-023 Grant: if exactly one reqN_valid is high, that requester is granted; if both are high, the requester other than last_grant is granted.
REQ-024 reqN_ready SHALL be high only when the accept slot is open, reqN_valid=1 and N is granted; combinational; at most one ready high per cycle.
REQ-025 On accept: latch reqN_a, reqN_b, reqN_func and id N into operand registers, set last_grant=N, go to EXEC.
REQ-026 alu_a, alu_b and alu_func SHALL be driven from the operand registers in every state, with no combinational path from req inputs.
REQ-027 EXEC (one cycle): capture alu_result, alu_zero and id into rsp registers; set rsp_err=(func>9); set rsp_valid=1; go to HOLD.
REQ-028 In HOLD with rsp_ready=0: all rsp outputs SHALL hold stable and no request is accepted.
REQ-029 HOLD with rsp_ready=1: rsp_valid clears and op_count increments; the next state is EXEC if a request is accepted in the same cycle, otherwise IDLE.
REQ-030 Latency SHALL be 2 cycles: accept at edge N gives rsp_valid=1 after edge N+1; sustained throughput is one operation per 2 cycles.
REQ-031 IDLE with no valid request: state and registers SHALL be unchanged.
REQ-032 rsp_err=1 SHALL NOT suppress the response; rsp_result is whatever the ALU returns (0 for illegal codes).

Reset
REQ-033 While rst=1 at a clock edge: state=IDLE, rsp_valid=0, rsp_id=0, rsp_result=0, rsp_zero=0, rsp_err=0, op_count=0, operand registers=0 (so alu_a, alu_b and alu_func are 0), last_grant=1 (requester 0 wins first tie).
REQ-034 While rst=1, both reqN_ready outputs SHALL be 0.
REQ-035 Reset in EXEC or HOLD SHALL discard the in-flight operation without a response and without incrementing op_count.

Verification
REQ-036 req0 add (func 0) a=5, b=7, rsp_ready=1 -> req0_ready=1 for one cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_result=12, rsp_zero=0, op_count becomes 1.
REQ-037 First cycle after reset, both valid: req0 sub 3-3, req1 OR 4|1 -> req0 served first (rsp_result=0, rsp_zero=1), then req1 (rsp_result=5, rsp_id=1); no cycle has both readys high.
REQ-038 Both requesters continuously valid for 6 operations with rsp_ready=1 -> grants alternate 0,1,0,1,0,1; one response every 2 cycles; op_count=6.
REQ-039 rsp_ready held 0 for 3 cycles in HOLD -> rsp_result and rsp_id stable and both readys 0; on rsp_ready=1 the pending req1 is accepted in that same cycle.
REQ-040 req1 func=4'hF -> rsp_err=1, rsp_result=0, response still delivered, op_count increments.
REQ-041 rst asserted in EXEC -> next cycle IDLE, rsp_valid=0, op_count unchanged at 0, alu_a=0.
